int_ctrl: RTL and testbench
===========================

# int_ctrl

Memory-mapped interrupt controller that generates the 5-bit `INT` vector consumed by the MIPS core. It synchronizes raw peripheral requests, latches them as pending (edge or level per source), applies a software mask, and drives masked pending bits to the core. It also exposes status through a responder port on the data-memory bus (`we`/`a`/`d`/`q`), decoded beside `dmem`.

## Interface
Parameters:
- `N_SRC`, 5: number of interrupt sources, equal to the core `INT` width.
- `DW`, 32: bus data width.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `irq_src` in N_SRC: raw peripheral requests; asynchronous to `clk`.
- `we` in 1: bus write strobe for this block; the decode is done outside.
- `a` in 3: word register index.
- `d` in DW: write data.
- `q` out DW: read data; combinational from `a` and register state.
- `INT` out N_SRC: registered interrupt vector to the core.

## Operation
Registers, indexed by `a`; unused bits read 0; writes to read-only registers are ignored:
- 0 PEND: read returns pending bits. Writing 1 to a bit clears it (W1C).
- 1 MASK: read/write; 1 enables the source.
- 2 MODE: read/write; 1 = edge, 0 = level.
- 3 ID: read-only. Bit 31 = any masked pending. Bits [2:0] = lowest set index of PEND&MASK, which is the highest priority. Reads 0 when none.
- 4 RAW: read-only; synchronized `irq_src`.
- 5 OVF: W1C sticky flag. Set when an edge-mode source produces a new edge while its PEND bit is already 1.
- 6–7: read 0, writes ignored.

Per-source behaviour, each cycle:
- Synchronizer: `s1 <= irq_src`, `s2 <= s1`, `s3 <= s2`.
- Edge event: `s2 & ~s3` (rising edge only).
- Edge mode:
  - PEND is set by an edge event.
  - PEND is cleared by W1C.
  - Set wins over a same-cycle clear.
  - OVF is set if an edge event occurs with PEND already 1 and not being cleared that cycle.
- Level mode:
  - PEND is set while `s2`=1.
  - W1C clears PEND only if `s2`=0 that cycle.
  - OVF is never set.
- Mode write: takes effect next cycle. PEND is not altered by the mode change itself. `s3` history is kept, so no spurious edge.
- `INT <= PEND & MASK`, registered, using the post-update values of the previous cycle.

## Timing
- Reset (`rst`=0, asynchronous): s1/s2/s3, PEND, MASK, MODE, OVF and `INT` all go to 0. `q` reads 0 for every address while in reset.
- Latency: edge-mode `irq_src` rises before clock edge E0:
  - PEND=1 after E2.
  - `INT`=1 after E3, provided MASK is set.
- W1C of PEND at clock edge Ek: PEND=0 after Ek; `INT`=0 after Ek+1.
- MASK write at Ek: `INT` reflects the new mask after Ek+1.
- Pulses shorter than one `clk` period may be missed; the minimum guaranteed pulse is 2 cycles.
- Reads: `q` is valid in the same cycle as `a`. A read in the same cycle as a write returns the pre-write value.
- Reset deasserted mid-pulse: if `irq_src` is already high at release, an edge-mode source sees no edge. A level-mode source pends 2 cycles after release.

## Structure
- Shared package `intc_pkg`:
  - register index constants: `INTC_PEND`=0, `INTC_MASK`=1, `INTC_MODE`=2, `INTC_ID`=3, `INTC_RAW`=4, `INTC_OVF`=5;
  - `N_SRC` default;
  - ID valid bit position (31).
- One sub-module `intc_src_cell`: the per-source synchronizer, edge detect, and PEND/OVF logic, instantiated N_SRC times.
- The top level holds MASK, MODE, `INT`, the priority encoder and the read mux.

## Test plan
- Reset: drive `rst`=0 mid-activity with PEND=5'b10101 → all registers and `INT` read 0 immediately (asynchronously); `q`=0 at all addresses.
- Edge latency: MASK=5'h1F, MODE=5'h1F, pulse `irq_src[2]` high for 3 cycles → PEND=5'b00100 after 3 edges, `INT`=5'b00100 after 4 edges, ID=32'h8000_0002.
- Clear/overflow: source 0 pending, second edge arrives → OVF=5'b00001. Write PEND←5'b00001 → PEND=0, `INT`[0]=0 one cycle later. Write OVF←1 → OVF=0.
- Set-vs-clear collision: W1C of bit 1 in the same cycle as an edge event on source 1 → PEND[1] stays 1 and OVF[1] stays 0.
- Level mode: MODE=0, hold `irq_src[4]`=1 → W1C has no effect and PEND[4]=1. Drop `irq_src[4]`, wait 2 cycles, W1C → PEND[4]=0.
- Masking/priority: PEND=5'b11000, MASK=5'b10000 → `INT`=5'b10000 and ID=32'h8000_0004. Set MASK=5'h1F → ID=32'h8000_0003.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, source count
// default and the position of the ID "any pending" flag.
package intc_pkg;

  localparam int INTC_N_SRC      = 5;
  localparam int INTC_ID_VLD_BIT = 31;

  localparam logic [2:0] INTC_PEND = 3'd0;
  localparam logic [2:0] INTC_MASK = 3'd1;
  localparam logic [2:0] INTC_MODE = 3'd2;
  localparam logic [2:0] INTC_ID   = 3'd3;
  localparam logic [2:0] INTC_RAW  = 3'd4;
  localparam logic [2:0] INTC_OVF  = 3'd5;

endpackage

// File: rtl/intc_src_cell.sv
// One interrupt source: 3-flop synchronizer, rising-edge detect and the
// PEND/OVF state for that source in either edge or level mode.
module intc_src_cell
  import intc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic pend_clr,
  input  logic ovf_clr,
  output logic pend,
  output logic ovf,
  output logic raw
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [2:0] warm_q, warm_d;
  logic       pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic       edge_ev;
  logic       set;

  // warm_q[2] marks s3 as holding a real sample, so a request already high at
  // reset release is not mistaken for a rising edge.
  always_comb begin
    s1_d    = irq;
    s2_d    = s1_q;
    s3_d    = s2_q;
    warm_d  = {warm_q[1:0], 1'b1};
    edge_ev = s2_q & ~s3_q & warm_q[2];
    set     = edge_mode ? edge_ev : s2_q;
    pend_d  = set | (pend_q & ~pend_clr);
    ovf_d   = (edge_mode & edge_ev & pend_q & ~pend_clr) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      warm_q <= 3'b000;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      warm_q <= warm_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend = pend_q;
  assign ovf  = ovf_q;
  assign raw  = s2_q;

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller driving the core INT vector; holds MASK,
// MODE and the registered INT, plus the ID priority encoder and read mux.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int N_SRC = INTC_N_SRC,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             we,
  input  logic [2:0]       a,
  input  logic [DW-1:0]    d,
  output logic [DW-1:0]    q,
  output logic [N_SRC-1:0] INT
);

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] int_vec_q, int_vec_d;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] ovf;
  logic [N_SRC-1:0] raw;
  logic [N_SRC-1:0] pend_clr;
  logic [N_SRC-1:0] ovf_clr;
  logic [N_SRC-1:0] pend_masked;
  logic             unused_d;

  assign unused_d = ^d[DW-1:N_SRC];

  // Lowest set index wins priority.
  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    intc_src_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .irq       (irq_src[i]),
      .edge_mode (mode_q[i]),
      .pend_clr  (pend_clr[i]),
      .ovf_clr   (ovf_clr[i]),
      .pend      (pend[i]),
      .ovf       (ovf[i]),
      .raw       (raw[i])
    );
  end

  always_comb begin
    pend_masked = pend & mask_q;
    pend_clr    = (we && a == INTC_PEND) ? d[N_SRC-1:0] : '0;
    ovf_clr     = (we && a == INTC_OVF)  ? d[N_SRC-1:0] : '0;
    mask_d      = (we && a == INTC_MASK) ? d[N_SRC-1:0] : mask_q;
    mode_d      = (we && a == INTC_MODE) ? d[N_SRC-1:0] : mode_q;
    int_vec_d   = pend_masked;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q    <= '0;
      mode_q    <= '0;
      int_vec_q <= '0;
    end else begin
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign INT = int_vec_q;

  // Read path is combinational and forced to zero while reset is held.
  always_comb begin
    q = '0;
    if (rst) begin
      case (a)
        INTC_PEND: q[N_SRC-1:0] = pend;
        INTC_MASK: q[N_SRC-1:0] = mask_q;
        INTC_MODE: q[N_SRC-1:0] = mode_q;
        INTC_ID: begin
          if (|pend_masked) begin
            q[INTC_ID_VLD_BIT] = 1'b1;
            q[2:0]             = lowest_idx(pend_masked);
          end
        end
        INTC_RAW:  q[N_SRC-1:0] = raw;
        INTC_OVF:  q[N_SRC-1:0] = ovf;
        default:   q = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboarded bench for int_ctrl: a cycle-level reference model predicts q and
// INT for every cycle, a negedge monitor pops and compares.
module tb_int_ctrl;
  import intc_pkg::*;

  localparam int N  = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq_src = '0;
  logic          we = 1'b0;
  logic [2:0]    a = '0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] q;
  logic [N-1:0]  INT;

  int_ctrl #(.N_SRC(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .we(we),
    .a(a), .d(d), .q(q), .INT(INT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  int_e;
    logic [DW-1:0] q_e;
    logic [2:0]    ra;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Reference model state: register contents and the irq samples seen at
  // each clock edge since reset (most recent at the back).
  logic [N-1:0] m_pend, m_mask, m_mode, m_ovf, m_int;
  logic [N-1:0] m_hist[$];

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Value of irq_src as seen k edges ago (1 = newest sample).
  function automatic logic [N-1:0] m_sync(input int k);
    if (m_hist.size() >= k) return m_hist[m_hist.size() - k];
    return '0;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [2:0] ra);
    logic [DW-1:0] r;
    logic [N-1:0]  pm;
    r  = '0;
    pm = m_pend & m_mask;
    case (ra)
      3'd0: r[N-1:0] = m_pend;
      3'd1: r[N-1:0] = m_mask;
      3'd2: r[N-1:0] = m_mode;
      3'd3: for (int i = N - 1; i >= 0; i--) if (pm[i]) r = 32'h8000_0000 | i;
      3'd4: r[N-1:0] = m_sync(2);
      3'd5: r[N-1:0] = m_ovf;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void m_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_ovf = '0; m_int = '0;
    m_hist.delete();
  endfunction

  // Apply one clock edge to the model with the inputs held during that cycle.
  function automatic void m_step(input logic [N-1:0] irq, input logic w,
                                 input logic [2:0] wa, input logic [DW-1:0] wd);
    logic [N-1:0] s2, s3, np, no;
    bit           hist_ok, clr, oclr, set, oset;
    s2      = m_sync(2);
    s3      = m_sync(3);
    hist_ok = (m_hist.size() >= 3);
    for (int i = 0; i < N; i++) begin
      clr  = w && wa == 3'd0 && wd[i];
      oclr = w && wa == 3'd5 && wd[i];
      if (m_mode[i]) begin
        set  = hist_ok && s2[i] && !s3[i];
        oset = set && m_pend[i] && !clr;
      end else begin
        set  = s2[i];
        oset = 1'b0;
      end
      np[i] = set || (m_pend[i] && !clr);
      no[i] = oset || (m_ovf[i] && !oclr);
    end
    m_int  = m_pend & m_mask;
    m_pend = np;
    m_ovf  = no;
    if (w && wa == 3'd1) m_mask = wd[N-1:0];
    if (w && wa == 3'd2) m_mode = wd[N-1:0];
    m_hist.push_back(irq);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
  endfunction

  // One bus cycle, entered and left at posedge+1.
  task automatic cyc_x(input logic [N-1:0] irq, input logic w, input logic [2:0] ra,
                       input logic [DW-1:0] wd, input bit has_exp,
                       input logic [DW-1:0] exp_q, input string nm);
    exp_t e;
    irq_src = irq; we = w; a = ra; d = wd;
    e.int_e = m_int; e.q_e = m_read(ra); e.ra = ra; e.cyc = cyc_no;
    sbq.push_back(e);
    if (has_exp) begin
      #1;
      chk(nm, q, exp_q);
    end
    @(posedge clk);
    m_step(irq, w, ra, wd);
    cyc_no++;
    #1;
  endtask

  task automatic cyc(input logic [N-1:0] irq, input logic w, input logic [2:0] ra,
                     input logic [DW-1:0] wd);
    cyc_x(irq, w, ra, wd, 1'b0, '0, "");
  endtask

  // Asynchronous reset mid-cycle, check outputs immediately, release at posedge+1.
  task automatic do_reset(input logic [N-1:0] irq_hold);
    #2;
    rst = 1'b0;
    we  = 1'b0;
    #1;
    chk("rst_int", DW'(INT), '0);
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      #1;
      chk($sformatf("rst_q a=%0d", i), q, '0);
    end
    m_reset();
    irq_src = irq_hold;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("sb_int cyc=%0d", e.cyc), DW'(INT), DW'(e.int_e));
        chk($sformatf("sb_q cyc=%0d a=%0d", e.cyc, e.ra), q, e.q_e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [N-1:0] irq_v;
    m_reset();
    @(posedge clk);
    #1;
    do_reset('0);

    // Edge latency on source 2.
    cyc(5'h00, 1'b1, INTC_MASK, 32'h1F);
    cyc(5'h00, 1'b1, INTC_MODE, 32'h1F);
    repeat (3) cyc(5'b00100, 1'b0, INTC_PEND, '0);
    cyc_x(5'h00, 1'b0, INTC_PEND, '0, 1'b1, 32'h4, "lat_pend");
    cyc_x(5'h00, 1'b0, INTC_ID, '0, 1'b1, 32'h8000_0002, "lat_id");
    cyc(5'h00, 1'b1, INTC_PEND, 32'h1F);
    repeat (2) cyc(5'h00, 1'b0, INTC_RAW, '0);

    // Overflow on source 0, then W1C of PEND and OVF.
    repeat (2) cyc(5'b00001, 1'b0, INTC_RAW, '0);
    repeat (3) cyc(5'b00000, 1'b0, INTC_PEND, '0);
    repeat (2) cyc(5'b00001, 1'b0, INTC_RAW, '0);
    repeat (3) cyc(5'b00000, 1'b0, INTC_OVF, '0);
    cyc_x(5'h00, 1'b0, INTC_OVF, '0, 1'b1, 32'h1, "ovf_set");
    cyc(5'h00, 1'b1, INTC_PEND, 32'h1);
    cyc_x(5'h00, 1'b0, INTC_PEND, '0, 1'b1, 32'h0, "pend_w1c");
    cyc(5'h00, 1'b1, INTC_OVF, 32'h1);
    cyc_x(5'h00, 1'b0, INTC_OVF, '0, 1'b1, 32'h0, "ovf_w1c");

    // W1C colliding with a new edge on source 1.
    repeat (2) cyc(5'b00010, 1'b0, INTC_RAW, '0);
    repeat (3) cyc(5'b00000, 1'b0, INTC_PEND, '0);
    repeat (2) cyc(5'b00010, 1'b0, INTC_PEND, '0);
    cyc(5'b00010, 1'b1, INTC_PEND, 32'h2);
    cyc_x(5'b00000, 1'b0, INTC_PEND, '0, 1'b1, 32'h2, "coll_pend");
    cyc_x(5'b00000, 1'b0, INTC_OVF, '0, 1'b1, 32'h0, "coll_ovf");
    cyc(5'h00, 1'b1, INTC_PEND, 32'h1F);

    // Level mode on source 4.
    cyc(5'h00, 1'b1, INTC_MODE, 32'h0);
    repeat (3) cyc(5'b10000, 1'b0, INTC_RAW, '0);
    cyc(5'b10000, 1'b1, INTC_PEND, 32'h10);
    cyc_x(5'b10000, 1'b0, INTC_PEND, '0, 1'b1, 32'h10, "lvl_hold");
    repeat (2) cyc(5'b00000, 1'b0, INTC_PEND, '0);
    cyc(5'b00000, 1'b1, INTC_PEND, 32'h10);
    cyc_x(5'b00000, 1'b0, INTC_PEND, '0, 1'b1, 32'h0, "lvl_clr");

    // Masking and priority with PEND = 11000.
    repeat (3) cyc(5'b11000, 1'b0, INTC_RAW, '0);
    repeat (3) cyc(5'b00000, 1'b0, INTC_PEND, '0);
    cyc(5'h00, 1'b1, INTC_MASK, 32'h10);
    cyc(5'h00, 1'b0, INTC_PEND, '0);
    cyc_x(5'h00, 1'b0, INTC_ID, '0, 1'b1, 32'h8000_0004, "prio_masked");
    cyc(5'h00, 1'b1, INTC_MASK, 32'h1F);
    cyc_x(5'h00, 1'b0, INTC_ID, '0, 1'b1, 32'h8000_0003, "prio_all");

    // Reset mid-activity with PEND = 10101.
    cyc(5'h00, 1'b1, INTC_PEND, 32'h1F);
    repeat (3) cyc(5'b10101, 1'b0, INTC_RAW, '0);
    repeat (3) cyc(5'b00000, 1'b0, INTC_PEND, '0);
    cyc_x(5'h00, 1'b0, INTC_PEND, '0, 1'b1, 32'h15, "pre_rst_pend");
    do_reset(5'b00110);

    // Requests high at release: edge mode must not see an edge.
    cyc(5'b00110, 1'b1, INTC_MODE, 32'h1F);
    cyc(5'b00110, 1'b1, INTC_MASK, 32'h1F);
    repeat (4) cyc(5'b00110, 1'b0, INTC_PEND, '0);
    cyc_x(5'b00110, 1'b0, INTC_PEND, '0, 1'b1, 32'h0, "rel_no_edge");

    // Randomized traffic, with one reset in the middle.
    irq_v = 5'b00110;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) irq_v[i] = ~irq_v[i];
      if (n == 200) do_reset(irq_v);
      cyc(irq_v, ($urandom_range(3) == 0), 3'($urandom_range(7)), $urandom);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", DW'(sbq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
